// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming popcount accumulator.
// Covers sum sizing, mode encoding and adder-tree cut placement.
package popcount_pkg;

  typedef enum logic {
    POPC_UNSIGNED = 1'b0,
    POPC_TERNARY  = 1'b1
  } mode_e;

  typedef struct packed {
    logic valid;
    logic last;
    logic trunc;
  } side_t;

  localparam int SIDE_W = $bits(side_t);

  function automatic int sum_width(
    input int n,
    input int max_beats
  );
    return $clog2(n * max_beats) + 2;
  endfunction

  // Cut s of `stages` lands after tree level floor(s*levels/stages).
  function automatic bit is_cut(
    input int lvl,
    input int levels,
    input int stages
  );
    bit hit;
    hit = 1'b0;
    for (int s = 1; s <= stages; s++) begin
      if ((s * levels) / stages == lvl) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Balanced N-input bit-count adder tree with optional register cuts.
// A side-band word travels alongside the data and shares its stalls.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int N          = 512,
  parameter int NUM_STAGES = 2,
  parameter int SBW        = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [N-1:0]         bits_i,
  input  logic [SBW-1:0]       side_i,
  output logic [$clog2(N):0]   cnt_o,
  output logic [SBW-1:0]       side_o
);

  localparam int L = $clog2(N);

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int M = N >> l;
    localparam bit CUT = is_cut(l, L, NUM_STAGES);

    logic [l:0]     d [M];
    logic [l:0]     q [M];
    logic [SBW-1:0] sd;
    logic [SBW-1:0] sq;

    for (genvar i = 0; i < M; i++) begin : g_add
      if (l == 1) begin : g_leaf
        assign d[i] = {1'b0, bits_i[2*i]}
                    + {1'b0, bits_i[2*i+1]};
      end else begin : g_node
        assign d[i] = {1'b0, g_lvl[l-1].q[2*i]}
                    + {1'b0, g_lvl[l-1].q[2*i+1]};
      end
    end

    if (l == 1) begin : g_sin
      assign sd = side_i;
    end else begin : g_sprev
      assign sd = g_lvl[l-1].sq;
    end

    if (CUT) begin : g_reg
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < M; i++) begin
            q[i] <= '0;
          end
          sq <= '0;
        end else if (clear_i) begin
          sq <= '0;
        end else if (en_i) begin
          q  <= d;
          sq <= sd;
        end
      end
    end else begin : g_wire
      assign q  = d;
      assign sq = sd;
    end
  end

  assign cnt_o  = g_lvl[L].q[0];
  assign side_o = g_lvl[L].sq;

endmodule

// File: rtl/popcount_acc.sv
// Streaming popcount / ternary-difference accumulator.
// Words flow through two adder trees; one signed sum per packet.
module popcount_acc
  import popcount_pkg::*;
#(
  parameter int  N          = 512,
  parameter int  NUM_STAGES = 2,
  parameter int  MAX_BEATS  = 16,
  localparam int SW = sum_width(N, MAX_BEATS),
  localparam int BW = $clog2(MAX_BEATS) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N-1:0]         in_a_i,
  input  logic [N-1:0]         in_b_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [SW-1:0] out_sum_o,
  output logic [BW-1:0]        out_beats_o,
  output logic                 out_trunc_o
);

  localparam int CW = $clog2(N) + 1;
  localparam int VW = CW + 1;

  logic          advance;
  logic          fire;
  logic          first;
  logic          at_max;
  logic [BW-1:0] in_cnt;
  mode_e         mode_q;
  mode_e         mode_cur;
  logic [N-1:0]  pos_bits;
  logic [N-1:0]  neg_bits;
  side_t         side_in;
  side_t         side_out;
  logic [0:0]    mode_in;
  logic [0:0]    mode_out;
  logic [CW-1:0] pos_cnt;
  logic [CW-1:0] neg_cnt;

  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance && rst_ni;
  assign fire       = in_valid_i && in_ready_o && !clear_i;

  // Packet framing lives at the input so the mode can mask stage 0.
  assign first    = (in_cnt == '0);
  assign at_max   = (in_cnt == BW'(MAX_BEATS - 1));
  assign mode_cur = first ? mode_e'(mode_i) : mode_q;

  assign side_in.valid = fire;
  assign side_in.last  = in_last_i || at_max;
  assign side_in.trunc = at_max && !in_last_i;
  assign mode_in       = mode_cur;

  assign pos_bits = (mode_cur == POPC_TERNARY)
                  ? (in_a_i & ~in_b_i) : in_a_i;
  assign neg_bits = in_b_i & ~in_a_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_cnt <= '0;
      mode_q <= POPC_UNSIGNED;
    end else if (clear_i) begin
      in_cnt <= '0;
    end else if (fire) begin
      in_cnt <= side_in.last ? '0 : in_cnt + BW'(1);
      mode_q <= mode_cur;
    end
  end

  popcount_tree #(
    .N          (N),
    .NUM_STAGES (NUM_STAGES),
    .SBW        (SIDE_W)
  ) u_pos (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (advance),
    .clear_i (clear_i),
    .bits_i  (pos_bits),
    .side_i  (side_in),
    .cnt_o   (pos_cnt),
    .side_o  (side_out)
  );

  popcount_tree #(
    .N          (N),
    .NUM_STAGES (NUM_STAGES),
    .SBW        (1)
  ) u_neg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (advance),
    .clear_i (clear_i),
    .bits_i  (neg_bits),
    .side_i  (mode_in),
    .cnt_o   (neg_cnt),
    .side_o  (mode_out)
  );

  logic signed [VW-1:0] v;
  logic signed [SW-1:0] v_ext;
  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] nacc;
  logic [BW-1:0]        acc_cnt;
  logic [BW-1:0]        cnt_n;
  logic                 tv;
  logic                 tl;

  always_comb begin
    v = $signed({1'b0, pos_cnt});
    if (mode_e'(mode_out) == POPC_TERNARY) begin
      v = v - $signed({1'b0, neg_cnt});
    end
    v_ext = {{(SW-VW){v[VW-1]}}, v};
    nacc  = (acc_cnt == '0) ? v_ext : acc + v_ext;
    cnt_n = acc_cnt + BW'(1);
  end

  assign tv = side_out.valid;
  assign tl = side_out.last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc         <= '0;
      acc_cnt     <= '0;
      out_valid_o <= 1'b0;
      out_sum_o   <= '0;
      out_beats_o <= '0;
      out_trunc_o <= 1'b0;
    end else if (clear_i) begin
      acc         <= '0;
      acc_cnt     <= '0;
      out_valid_o <= 1'b0;
      out_sum_o   <= '0;
      out_beats_o <= '0;
      out_trunc_o <= 1'b0;
    end else if (advance) begin
      unique case (1'b1)
        tv && tl: begin
          out_valid_o <= 1'b1;
          out_sum_o   <= nacc;
          out_beats_o <= cnt_n;
          out_trunc_o <= side_out.trunc;
          acc         <= '0;
          acc_cnt     <= '0;
        end
        tv && !tl: begin
          out_valid_o <= 1'b0;
          acc         <= nacc;
          acc_cnt     <= cnt_n;
        end
        !tv: begin
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_acc.sv
// Bench for popcount_acc: directed cases plus random traffic
// scored against a per-packet arithmetic model.
module tb_popcount_acc;

  localparam int N  = 512;
  localparam int NS = 2;
  localparam int MB = 16;
  localparam int SW = $clog2(N * MB) + 2;
  localparam int BW = $clog2(MB) + 1;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 clear = 1'b0;
  logic                 mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N-1:0]         in_a = '0;
  logic [N-1:0]         in_b = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [SW-1:0] out_sum;
  logic [BW-1:0]        out_beats;
  logic                 out_trunc;

  popcount_acc #(
    .N          (N),
    .NUM_STAGES (NS),
    .MAX_BEATS  (MB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_beats_o (out_beats),
    .out_trunc_o (out_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int sum;
    int beats;
    int trunc;
  } res_t;

  res_t exq[$];
  int   pk_cnt = 0;
  int   pk_sum = 0;
  logic pk_mode = 1'b0;
  bit   held = 0;
  int   h_sum, h_beats, h_trunc;

  // Model: per-packet sums from $countones, closed on last or MB.
  task automatic model_beat();
    int v;
    res_t r;
    if (pk_cnt == 0) pk_mode = mode;
    if (pk_mode)
      v = $countones(in_a & ~in_b) - $countones(in_b & ~in_a);
    else
      v = $countones(in_a);
    pk_sum += v;
    pk_cnt++;
    if (in_last || pk_cnt == MB) begin
      r.sum   = pk_sum;
      r.beats = pk_cnt;
      r.trunc = (!in_last && pk_cnt == MB) ? 1 : 0;
      exq.push_back(r);
      pk_cnt = 0;
      pk_sum = 0;
    end
  endtask

  task automatic model_flush();
    exq.delete();
    pk_cnt = 0;
    pk_sum = 0;
    held   = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      model_flush();
    end else begin
      check("in_ready", int'(in_ready),
            int'(!out_valid || out_ready));
      if (held) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_sum", int'(out_sum), h_sum);
        check("hold_beats", int'(out_beats), h_beats);
        check("hold_trunc", int'(out_trunc), h_trunc);
      end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exq.pop_front();
          check("sum", int'(out_sum), e.sum);
          check("beats", int'(out_beats), e.beats);
          check("trunc", int'(out_trunc), e.trunc);
        end
      end
      held    = out_valid && !out_ready && !clear;
      h_sum   = int'(out_sum);
      h_beats = int'(out_beats);
      h_trunc = int'(out_trunc);
      if (clear) model_flush();
      else if (in_valid && in_ready) model_beat();
    end
  end

  task automatic send(input logic [N-1:0] a,
                      input logic [N-1:0] b,
                      input logic m, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    mode = m;
    in_last = l;
    @(negedge clk);
    while (!(in_ready && !clear) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] r;
    logic [31:0]  w;
    int k;
    k = $urandom_range(0, 3);
    for (int i = 0; i < N / 32; i++) begin
      w = $urandom;
      case (k)
        1: w &= $urandom;
        2: w |= $urandom;
        3: w = ($urandom_range(0, 1) != 0) ? '1 : '0;
        default: ;
      endcase
      r[i*32 +: 32] = w;
    end
    return r;
  endfunction

  logic [N-1:0] ones;
  logic [N-1:0] one;
  logic [N-1:0] v8;
  logic [N-1:0] v20;
  int lat;
  bit rnd_on;

  initial begin
    ones = '1;
    one  = '0;
    one[0] = 1'b1;
    v8   = '0;
    v8[7:0] = '1;
    v20  = '0;
    v20[19:0] = '1;

    #2;
    check("rst_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_sum", int'(out_sum), 0);
    check("rst_beats", int'(out_beats), 0);
    check("rst_trunc", int'(out_trunc), 0);
    rst_ni = 1'b1;
    realign();

    // Single all-ones beat, latency check.
    out_ready = 1'b1;
    send(ones, '0, 1'b0, 1'b1);
    wait_out(lat);
    check("latency", lat, NS + 1);
    check("t1_sum", int'(out_sum), 512);
    check("t1_beats", int'(out_beats), 1);
    check("t1_trunc", int'(out_trunc), 0);
    realign();

    // Ternary 3-beat packet; later beats flip mode_i.
    send(v8, '0, 1'b1, 1'b0);
    send('0, v20, 1'b0, 1'b0);
    send(ones, ones, 1'b0, 1'b1);
    wait_out(lat);
    check("t2_valid", int'(out_valid), 1);
    check("t2_sum", int'(out_sum), -12);
    check("t2_beats", int'(out_beats), 3);
    check("t2_trunc", int'(out_trunc), 0);
    realign();

    // 16 beats without last force-close the packet.
    for (int i = 0; i < MB; i++) send(one, '0, 1'b0, 1'b0);
    wait_out(lat);
    check("t3_valid", int'(out_valid), 1);
    check("t3_sum", int'(out_sum), 16);
    check("t3_beats", int'(out_beats), 16);
    check("t3_trunc", int'(out_trunc), 1);
    realign();
    send(one, '0, 1'b0, 1'b1);
    wait_out(lat);
    check("t3b_sum", int'(out_sum), 1);
    check("t3b_beats", int'(out_beats), 1);
    check("t3b_trunc", int'(out_trunc), 0);
    realign();

    // Back-to-back packets under a 5-cycle output stall.
    out_ready = 1'b0;
    fork
      begin
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        send(rand_vec(), rand_vec(), 1'b0, 1'b1);
        send(rand_vec(), rand_vec(), 1'b0, 1'b1);
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        send(rand_vec(), rand_vec(), 1'b0, 1'b0);
        send(rand_vec(), rand_vec(), 1'b1, 1'b1);
      end
      begin
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_ready", int'(in_ready), 0);
        end
        realign();
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 60 && (exq.size() != 0 || out_valid); i++)
      @(negedge clk);
    check("t4_drained", exq.size(), 0);
    realign();

    // Clear with a pending result and two beats in flight.
    out_ready = 1'b0;
    send(ones, '0, 1'b0, 1'b1);
    send(ones, '0, 1'b0, 1'b0);
    send(ones, '0, 1'b0, 1'b0);
    check("t5_pending", int'(out_valid), 1);
    clear = 1'b1;
    in_valid = 1'b1;
    in_a = ones;
    in_last = 1'b1;
    realign();
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_cleared", int'(out_valid), 0);
    realign();
    out_ready = 1'b1;
    send(512'h3, '0, 1'b0, 1'b1);
    wait_out(lat);
    check("t5_sum", int'(out_sum), 2);
    check("t5_beats", int'(out_beats), 1);
    realign();

    // Asynchronous reset mid-packet with a pending result.
    out_ready = 1'b0;
    send(ones, '0, 1'b0, 1'b1);
    send(rand_vec(), '0, 1'b0, 1'b0);
    send(rand_vec(), '0, 1'b0, 1'b0);
    check("t6_pre_valid", int'(out_valid), 1);
    check("t6_pre_sum", int'(out_sum), 512);
    #3;
    rst_ni = 1'b0;
    #1;
    check("t6_valid", int'(out_valid), 0);
    check("t6_sum", int'(out_sum), 0);
    check("t6_beats", int'(out_beats), 0);
    check("t6_ready", int'(in_ready), 0);
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    realign();
    out_ready = 1'b1;
    send(512'h7, '0, 1'b0, 1'b0);
    send(512'h1, '0, 1'b0, 1'b1);
    wait_out(lat);
    check("t6_post_sum", int'(out_sum), 4);
    check("t6_post_beats", int'(out_beats), 2);
    realign();

    // Random traffic with random backpressure and clears.
    rnd_on = 1;
    fork
      begin
        for (int p = 0; p < 400; p++) begin
          int plen;
          logic pm;
          plen = $urandom_range(1, 20);
          pm = logic'($urandom_range(0, 1));
          if ($urandom_range(0, 39) == 0) begin
            clear = 1'b1;
            realign();
            clear = 1'b0;
          end
          for (int b = 0; b < plen; b++) begin
            send(rand_vec(), rand_vec(), pm ^ (b == 2),
                 b == plen - 1);
            if ($urandom_range(0, 4) == 0) realign();
          end
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          realign();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (exq.size() != 0 || out_valid); i++)
      @(negedge clk);
    check("final_drained", exq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
